led_matrix_scan: RTL
====================

# led_matrix_scan

Receiving end of the game logic's 10-bit time-multiplexed pixel stream (`LEDout`). The block decodes each pixel code and accumulates lit pixels into a double-buffered 16-row × 8-column red/green frame. It then drives the dot-matrix with one row active at a time, inserting a blanking gap between rows to suppress ghosting. It sits between the game core and the board's LED matrix pins.

## Interface
- `ACCUM_CYCLES`, 256128: clocks per accumulation frame. Covers one full 128-slot transmitter sweep of 2001 clocks per slot.
- `ROW_DWELL`, 2000: clocks a row is driven.
- `BLANK_CYCLES`, 16: clocks of all-off between rows; must be ≥1.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `LEDIN`  in  10  pixel code:
  - [9] red; [8] green; [7] reserved, must be 0.
  - [6:3] row y, 0..15; [2:0] column x, 0..7.
- `ROWSEL`  out  16  one-hot row drive; bit y drives row y; active high.
- `COLR`  out  8  red column drive; bit x lights column x; active high.
- `COLG`  out  8  green column drive; active high.
- `FRAME_TICK`  out  1  one-cycle pulse after each buffer swap.
- `CODE_ERR`  out  1  sticky flag: a code with [7]=1 was received.

## Operation
- **Input stage.** `LEDIN` is registered every clock into `lin_q`.
  - Code with [9:8]=00: idle, no write.
  - Code with [7]=1: not written; sets `CODE_ERR`, which stays 1 until reset.
  - Otherwise: OR red bit into `back_r[y][x]` and green bit into `back_g[y][x]`.
  - Repeated codes (the transmitter holds each slot ~2001 clocks) are idempotent.
- **Accumulator.** 18-bit `acc_cnt` counts 0..`ACCUM_CYCLES`-1 and wraps.
- **Swap.** On the edge where `acc_cnt`=`ACCUM_CYCLES`-1:
  - `front` ← `back` as it stood before this edge.
  - `back` is cleared, except for the write from `lin_q` on this same edge, which lands in the new back buffer.
  - `FRAME_TICK` is 1 for exactly the following cycle.
- **Scanner FSM**, two states:
  - **BLANK**: `ROWSEL`=0, `COLR`=`COLG`=0. Counter runs 0..`BLANK_CYCLES`-1. On the last count go to DRIVE and load `ROWSEL`←1<<row, `COLR`←`front_r[row]`, `COLG`←`front_g[row]`.
  - **DRIVE**: outputs held constant. Counter runs 0..`ROW_DWELL`-1. On the last count go to BLANK, clear all outputs, row ← (row+1) mod 16 (15 wraps to 0).
- **Tearing.** Column data is latched only on BLANK→DRIVE. A swap during DRIVE does not change the row being shown; the new frame appears from the next row.
- **Simultaneous swap and row load.** The scanner reads `front` before that edge's update, i.e. the old frame.
- **Reset (asynchronous, any time including mid-scan).**
  - Outputs: all outputs 0.
  - State: buffers cleared, `acc_cnt`=0, row=0, state BLANK, counters 0, `lin_q`=0.

## Timing
- All outputs are registered; no combinational path from `LEDIN` to any output.
- Code present at edge k is written to `back` at edge k+1.
- First swap happens at edge `ACCUM_CYCLES` after reset release; swaps repeat every `ACCUM_CYCLES` clocks.
- Row 0 is first driven `BLANK_CYCLES` clocks after reset release.
- Full refresh period is 16×(`ROW_DWELL`+`BLANK_CYCLES`) clocks.
- A pixel first appears on the matrix at most `ACCUM_CYCLES` + 1 + 16×(`ROW_DWELL`+`BLANK_CYCLES`) clocks after its code is first presented.

## Test plan
Bench parameters: `ACCUM_CYCLES`=64, `ROW_DWELL`=4, `BLANK_CYCLES`=1.
- **Reset.** Hold RSTn=0 with `LEDIN`=10'h3FF → all outputs 0. Release → `ROWSEL`=16'h0001 first appears at cycle 1 with `COLR`=`COLG`=0; `FRAME_TICK` first pulses after edge 64.
- **Single red pixel.** `LEDIN`=10'b10_0_1100_010 (red, y=12, x=2) for 10 cycles, then 0. After the first `FRAME_TICK`: while `ROWSEL`=16'h1000, `COLR`=8'h04 and `COLG`=8'h00; every other row shows 0.
- **Red and green on one pixel.** Red code then green code for y=3, x=7 in the same frame. While `ROWSEL`=16'h0008: `COLR`=`COLG`=8'h80.
- **Clear between frames.** Send a pixel in frame 1 and nothing in frame 2. The pixel is lit during frame 1's display and all rows are dark after the second swap.
- **Code error.** `LEDIN`=10'b10_1_0000_000 → no pixel lit after the swap; `CODE_ERR`=1 and it stays 1 until RSTn=0.
- **Reset mid-scan.** Drop RSTn while `ROWSEL`=16'h0020 → all outputs 0 within the same cycle (asynchronous). After release: front buffer empty and the scan restarts at row 0.

Source files
------------

// File: rtl/led_matrix_scan.sv
// LED dot-matrix receiver: accumulates the 10-bit pixel stream into a
// double-buffered 16x8 red/green frame and scans it one row at a time.
module led_matrix_scan #(
  parameter int ACCUM_CYCLES = 256128,
  parameter int ROW_DWELL    = 2000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  LEDIN,
  output logic [15:0] ROWSEL,
  output logic [7:0]  COLR,
  output logic [7:0]  COLG,
  output logic        FRAME_TICK,
  output logic        CODE_ERR
);

  localparam int SMAX =
    (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int CW = $clog2(SMAX + 1);

  localparam logic [17:0]   ACC_LAST = 18'(ACCUM_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRV_LAST = CW'(ROW_DWELL - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [9:0]       lin_q;
  logic [17:0]      acc_cnt;
  logic             swap;
  logic             pix_wr;
  logic [3:0]       pix_y;
  logic [2:0]       pix_x;

  logic [15:0][7:0] back_r;
  logic [15:0][7:0] back_g;
  logic [15:0][7:0] back_r_nx;
  logic [15:0][7:0] back_g_nx;
  logic [15:0][7:0] front_r;
  logic [15:0][7:0] front_g;

  logic [0:0]       state;
  logic [CW-1:0]    scan_cnt;
  logic [3:0]       row;

  assign swap   = (acc_cnt == ACC_LAST);
  assign pix_wr = (lin_q[9:8] != 2'b00) && !lin_q[7];
  assign pix_y  = lin_q[6:3];
  assign pix_x  = lin_q[2:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lin_q <= '0;
    end else begin
      lin_q <= LEDIN;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      CODE_ERR <= 1'b0;
    end else if (lin_q[7]) begin
      CODE_ERR <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      acc_cnt    <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= swap;
      if (swap) begin
        acc_cnt <= '0;
      end else begin
        acc_cnt <= acc_cnt + 18'd1;
      end
    end
  end

  // The write arriving on the swap edge belongs to the new back buffer.
  always_comb begin
    back_r_nx = swap ? '0 : back_r;
    back_g_nx = swap ? '0 : back_g;
    if (pix_wr) begin
      back_r_nx[pix_y][pix_x] = back_r_nx[pix_y][pix_x] | lin_q[9];
      back_g_nx[pix_y][pix_x] = back_g_nx[pix_y][pix_x] | lin_q[8];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      back_r  <= '0;
      back_g  <= '0;
      front_r <= '0;
      front_g <= '0;
    end else begin
      back_r <= back_r_nx;
      back_g <= back_g_nx;
      if (swap) begin
        front_r <= back_r;
        front_g <= back_g;
      end
    end
  end

  // Column data is latched only on entry to DRIVE, so a swap never
  // tears the row currently on display.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_BLANK;
      scan_cnt <= '0;
      row      <= '0;
      ROWSEL   <= '0;
      COLR     <= '0;
      COLG     <= '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (scan_cnt == BLK_LAST) begin
            state    <= ST_DRIVE;
            scan_cnt <= '0;
            ROWSEL   <= 16'd1 << row;
            COLR     <= front_r[row];
            COLG     <= front_g[row];
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (scan_cnt == DRV_LAST) begin
            state    <= ST_BLANK;
            scan_cnt <= '0;
            row      <= row + 4'd1;
            ROWSEL   <= '0;
            COLR     <= '0;
            COLG     <= '0;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_BLANK;
          scan_cnt <= '0;
        end
      endcase
    end
  end

endmodule
